// File: rtl/ms_pkg.sv
// Shared definitions for the ms_ctrl convolution sequencer: FSM states and
// elaboration-time width / block-count helpers.
package ms_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } ms_state_e;

   // ceil(log2(x)), never less than 1 so a 1-entry range still gets a bit
   function automatic int clog2(input int x);
      int r;
      r = 1;
      while ((1 << r) < x) r++;
      return r;
   endfunction

   // bits needed to hold the value x itself (coefficient fields 0..x)
   function automatic int vbits(input int x);
      return clog2(x + 1);
   endfunction

   function automatic int calc_blocks(input int n, input int m);
      return (n + m - 1) / m;
   endfunction

endpackage

// File: rtl/ms_idx_gen.sv
// Modulo-N index register: clear, load or advance by a fixed STEP, with a
// single conditional subtract instead of a divider.
module ms_idx_gen
   import ms_pkg::*;
#(
   parameter int  N    = 7,
   parameter int  STEP = 1,
   localparam int W    = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         adv,
   output logic [W-1:0] idx
);

   localparam logic [W:0] N_X    = (W+1)'(N);
   localparam logic [W:0] STEP_X = (W+1)'(STEP % N);

   logic [W-1:0] idx_q, idx_d;
   logic [W:0]   sum_raw, sum_mod;

   always_comb begin
      sum_raw = {1'b0, idx_q} + STEP_X;
      sum_mod = (sum_raw >= N_X) ? sum_raw - N_X : sum_raw;
      idx_d   = idx_q;
      if (clr)      idx_d = '0;
      else if (ld)  idx_d = ld_val;
      else if (adv) idx_d = sum_mod[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) idx_q <= '0;
      else     idx_q <= idx_d;
   end

   assign idx = idx_q;

endmodule

// File: rtl/ms_ctrl.sv
// Sequencer for a ternary x mod-q polynomial multiply over M parallel AUs.
// Optional MS_CTRL_SKIP_ZERO_EN: skip outer iterations whose r coefficient is 0.
module ms_ctrl
   import ms_pkg::*;
#(
   parameter int  N  = 509,
   parameter int  q  = 2048,
   parameter int  p  = 3,
   parameter int  M  = 1,
   localparam int QW = vbits(q - 1),
   localparam int RW = vbits(p - 1),
   localparam int NW = clog2(N),
   localparam int B  = calc_blocks(N, M),
   localparam int BW = clog2(B)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] r_addr,
   input  logic [RW-1:0] r_data,
   output logic [RW-1:0] r_out,
   output logic [NW-1:0] h_idx,
   output logic [BW-1:0] e_raddr,
   output logic [BW-1:0] e_waddr,
   output logic          e_we,
   output logic [M-1:0]  lane_en
);

   if (B < 2 || p < 2 || QW < 1) begin : g_bad_cfg
      $error("ms_ctrl: unsupported parameter set");
   end

   localparam logic [BW-1:0] K_LAST     = BW'(B - 1);
   localparam logic [BW-1:0] K_PEN      = BW'(B - 2);
   localparam logic [NW-1:0] J_LAST     = NW'(N - 1);
   localparam int            LAST_LANES = N - (B - 1) * M;

   ms_state_e     state_q, state_d;
   logic [BW-1:0] k_q, k_d;
   logic [NW-1:0] r_addr_q, r_addr_d;
   logic [RW-1:0] r_out_q, r_out_d;
   logic          e_we_q, e_we_d;
   logic [BW-1:0] e_waddr_q, e_waddr_d;
   logic [M-1:0]  lane_en_q, lane_en_d, last_mask;
   logic [NW-1:0] j_idx, h_ld_val;
   logic          k_wrap, j_last, j_clr, adv_iter, h_adv;
`ifdef MS_CTRL_SKIP_ZERO_EN
   logic          fph_q, fph_d, r_zero;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
`ifdef MS_CTRL_SKIP_ZERO_EN
         // second FETCH phase sees r_data and decides run / skip
         S_FETCH: if (fph_q) state_d = !r_zero ? S_RUN : (j_last ? S_DRAIN : S_FETCH);
         S_RUN:   if (k_wrap) state_d = j_last ? S_DRAIN : S_FETCH;
`else
         S_FETCH: state_d = S_RUN;
         S_RUN:   if (k_wrap && j_last) state_d = S_DRAIN;
`endif
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DRAIN);
   end

   always_comb begin
      last_mask = '0;
      for (int i = 0; i < M; i++) last_mask[i] = (i < LAST_LANES);
   end

   always_comb begin
      k_wrap   = (state_q == S_RUN) && (k_q == K_LAST);
      j_last   = (j_idx == J_LAST);
      j_clr    = (state_q == S_IDLE) && start;
`ifdef MS_CTRL_SKIP_ZERO_EN
      r_zero   = (r_data == '0);
      adv_iter = (k_wrap || (state_q == S_FETCH && fph_q && r_zero)) && !j_last;
`else
      adv_iter = k_wrap && !j_last;
`endif
      h_adv    = (state_q == S_RUN) && !k_wrap;
      // window base for the next j is (-(j+1)) mod N = N-1-j
      h_ld_val = J_LAST - j_idx;
      k_d      = '0;
      if (state_q == S_RUN && !k_wrap) k_d = k_q + BW'(1);
      r_addr_d = r_addr_q;
      if (j_clr) r_addr_d = '0;
`ifdef MS_CTRL_SKIP_ZERO_EN
      else if (adv_iter) r_addr_d = j_idx + NW'(1);
      fph_d   = (state_q == S_FETCH) && !fph_q;
      r_out_d = (state_q == S_FETCH && fph_q) ? r_data : r_out_q;
`else
      // prefetch next r so it lands exactly on block 0 of the next iteration
      else if (state_q == S_RUN && k_q == K_PEN && !j_last) r_addr_d = j_idx + NW'(1);
      r_out_d = (state_q == S_RUN && k_q == '0) ? r_data : r_out_q;
`endif
      e_we_d    = (state_q == S_RUN);
      e_waddr_d = k_q;
      lane_en_d = '0;
      if (state_q == S_RUN) lane_en_d = (k_q == K_LAST) ? last_mask : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q       <= '0;
         r_addr_q  <= '0;
         r_out_q   <= '0;
         e_we_q    <= 1'b0;
         e_waddr_q <= '0;
         lane_en_q <= '0;
`ifdef MS_CTRL_SKIP_ZERO_EN
         fph_q     <= 1'b0;
`endif
      end else begin
         k_q       <= k_d;
         r_addr_q  <= r_addr_d;
         r_out_q   <= r_out_d;
         e_we_q    <= e_we_d;
         e_waddr_q <= e_waddr_d;
         lane_en_q <= lane_en_d;
`ifdef MS_CTRL_SKIP_ZERO_EN
         fph_q     <= fph_d;
`endif
      end
   end

   ms_idx_gen #(.N(N), .STEP(1)) u_j_gen (
      .clk(clk), .rst(rst), .clr(j_clr), .ld(1'b0), .ld_val('0),
      .adv(adv_iter), .idx(j_idx)
   );

   ms_idx_gen #(.N(N), .STEP(M)) u_h_gen (
      .clk(clk), .rst(rst), .clr(j_clr), .ld(adv_iter), .ld_val(h_ld_val),
      .adv(h_adv), .idx(h_idx)
   );

   assign r_addr  = r_addr_q;
   assign r_out   = r_out_q;
   assign e_raddr = k_q;
   assign e_waddr = e_waddr_q;
   assign e_we    = e_we_q;
   assign lane_en = lane_en_q;

endmodule

// File: tb/tb_ms_ctrl.sv
// Bench for ms_ctrl at N=7, M=2 (B=4): run table plus reset / re-start corners,
// with a write scoreboard fed from an independent (k*M - j) mod N model.
module tb_ms_ctrl;

   localparam int N = 7;
   localparam int M = 2;
   localparam int B = 4;
`ifdef MS_CTRL_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start;
   logic       busy, done, e_we;
   logic [2:0] r_addr, h_idx;
   logic [1:0] r_data, r_out, e_raddr, e_waddr, lane_en;
   logic [1:0] rmem [8];

   always #5 clk = ~clk;

   ms_ctrl #(.N(N), .q(2048), .p(3), .M(M)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .r_addr(r_addr), .r_data(r_data), .r_out(r_out), .h_idx(h_idx),
      .e_raddr(e_raddr), .e_waddr(e_waddr), .e_we(e_we), .lane_en(lane_en)
   );

   always @(posedge clk) r_data <= rmem[r_addr];

   typedef struct packed {
      logic [1:0] waddr;
      logic [1:0] r;
      logic [1:0] lane;
      logic [1:0] raddr;
      logic [2:0] h;
   } wr_t;

   typedef struct {
      logic [N-1:0][1:0] r;
      int                writes;
      int                lat;
   } vec_t;

   wr_t wq[$];
   int  n_chk = 0, n_pass = 0;
   int  cyc = 0, wr_cnt = 0, done_cnt = 0;
   logic [1:0] prev_raddr = '0;
   logic [2:0] prev_h = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_run(input logic [N-1:0][1:0] rv);
      wr_t w;
      for (int j = 0; j < N; j++) begin
         if (SKIP && rv[j] == 2'd0) continue;
         for (int k = 0; k < B; k++) begin
            w.waddr = 2'(k);
            w.r     = rv[j];
            w.lane  = (k == B - 1) ? 2'b01 : 2'b11;
            w.raddr = 2'(k);
            w.h     = 3'((((k * M - j) % N) + N) % N);
            wq.push_back(w);
         end
      end
   endtask

   // write-side monitor: every e_we pops one expectation; read fields come from the prior cycle
   always @(negedge clk) begin
      wr_t got;
      if (e_we) begin
         wr_cnt++;
         got = '{waddr: e_waddr, r: r_out, lane: lane_en, raddr: prev_raddr, h: prev_h};
         if (wq.size() == 0) check("unexpected_write", 32'(got), 32'hFFFF_FFFF);
         else check("write_rec", 32'(got), 32'(wq.pop_front()));
      end
      if (done) begin
         done_cnt++;
         check("done_with_final_we", 32'(e_we), 32'd1);
      end
      prev_raddr = e_raddr;
      prev_h     = h_idx;
   end

   // pulse start, return the edge count that sampled it
   task automatic kick(output int s_edge);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      s_edge = cyc;
   endtask

   task automatic wait_done(input string tag, output int at);
      int c;
      c = 0;
      while (!done && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
      at = cyc;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int s, at, w0;
      for (int j = 0; j < N; j++) rmem[j] = v.r[j];
      push_run(v.r);
      w0 = wr_cnt;
      kick(s);
      wait_done(tag, at);
      check({tag, "_latency"}, 32'(at - s + 1), 32'(v.lat));
      @(negedge clk);
      check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(v.writes));
      check({tag, "_sb_empty"}, 32'(wq.size()), 32'd0);
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   vec_t vt[4];

   initial begin
      int s, at, w0, d0;
      vec_t ones;
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) rmem[i] = 2'd1;

      vt[0] = '{r: {2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, writes: 28, lat: SKIP ? 43 : 30};
      vt[1] = '{r: {2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, writes: SKIP ? 8 : 28, lat: SKIP ? 23 : 30};
      vt[2] = '{r: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, writes: 28, lat: SKIP ? 43 : 30};
      vt[3] = '{r: {2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2}, writes: SKIP ? 20 : 28, lat: SKIP ? 35 : 30};
      ones  = vt[0];

      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_e_we",    32'(e_we),    32'd0);
      check("rst_lane_en", 32'(lane_en), 32'd0);
      check("rst_r_out",   32'(r_out),   32'd0);
      check("rst_r_addr",  32'(r_addr),  32'd0);
      check("rst_h_idx",   32'(h_idx),   32'd0);
      check("rst_e_raddr", 32'(e_raddr), 32'd0);
      check("rst_e_waddr", 32'(e_waddr), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_no_start", 32'(busy), 32'd0);

      foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

      // start re-pulsed mid-run must be ignored
      for (int j = 0; j < N; j++) rmem[j] = 2'd1;
      push_run(ones.r);
      w0 = wr_cnt;
      d0 = done_cnt;
      kick(s);
      for (int c = 1; c <= 45; c++) begin
         start = (c == 5 || c == 20);
         @(negedge clk);
      end
      start = 1'b0;
      check("repulse_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("repulse_writes",   32'(wr_cnt - w0),   32'd28);
      check("repulse_sb_empty", 32'(wq.size()),     32'd0);

      // reset in cycle 10 of a run aborts cleanly
      push_run(ones.r);
      kick(s);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_e_we", 32'(e_we), 32'd0);
      rst = 1'b0;
      wq.delete();
      repeat (3) @(negedge clk);
      check("abort_quiet", 32'(e_we | busy), 32'd0);
      run_vec(ones, "post_abort");

      // start held high: one idle cycle after done, then a second full run
      push_run(ones.r);
      push_run(ones.r);
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      wait_done("held1", at);
      @(negedge clk);
      check("held_idle_gap", 32'(busy), 32'd0);
      @(negedge clk);
      check("held_relaunch", 32'(busy), 32'd1);
      start = 1'b0;
      @(negedge clk);
      wait_done("held2", at);
      @(negedge clk);
      check("held_done_cnt", 32'(done_cnt - d0), 32'd2);
      check("held_writes",   32'(wr_cnt - w0),   32'd56);
      check("held_sb_empty", 32'(wq.size()),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
